rf_multiport: RTL and testbench

Parametrised multi-read-port register file for the single-cycle MIPS datapath. It adds the following to the two-read, one-write 32×32 file:
- a hardwired-zero register 0;
- optional write-to-read bypass;
- a configurable link-register write offset;
- synchronous clear;
- a sequential debug dump port that streams every register once, one per cycle, in place of simulation-only printing.

It sits between decode (read addresses) and writeback (write port).

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_multiport_if.sv | 36 +++
 rtl/rf_dump_ctrl.sv | 80 ++++++++
 rtl/rf_multiport.sv | 77 +++++++
 tb/tb_rf_multiport.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared types and constants for the multi-port register file.
//   dump_state_e    - dump sequencer states (IDLE, RUN, DONE)
//   ZERO_REG        - index of the hardwired-zero register
//   DEF_LINK_REG    - default register that receives the link offset on write
//   DEF_LINK_OFFSET - default value added to write data for the link register
package rf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dump_state_e;

    localparam int unsigned ZERO_REG        = 0;
    localparam int unsigned DEF_LINK_REG    = 31;
    localparam int unsigned DEF_LINK_OFFSET = 4;

endpackage

// File: rtl/rf_multiport_if.sv
// rf_multiport_if: read/write/dump bus of the multi-port register file.
//   ra, rd                  - NREAD packed read address / read data lanes
//   we, wa, wd              - single write port
//   dump_start              - request a full-register dump
//   dump_busy/valid/done    - dump sequence status
//   dump_idx, dump_data     - register being streamed out and its contents
// master = decode/writeback side, slave = register file.
interface rf_multiport_if #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NREAD = 2
) ();

    logic [NREAD*AW-1:0] ra;
    logic [NREAD*DW-1:0] rd;
    logic                we;
    logic [AW-1:0]       wa;
    logic [DW-1:0]       wd;
    logic                dump_start;
    logic                dump_busy;
    logic                dump_valid;
    logic [AW-1:0]       dump_idx;
    logic [DW-1:0]       dump_data;
    logic                dump_done;

    modport master (
        output ra, we, wa, wd, dump_start,
        input  rd, dump_busy, dump_valid, dump_idx, dump_data, dump_done
    );

    modport slave (
        input  ra, we, wa, wd, dump_start,
        output rd, dump_busy, dump_valid, dump_idx, dump_data, dump_done
    );

endinterface

// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: sequencer that walks every register index once per dump.
//   clk, rst  - clock, synchronous active-high reset
//   start_i   - dump request, honoured only in IDLE
//   busy_o    - sequence in progress (RUN or DONE)
//   valid_o   - idx_o names a register being dumped this cycle
//   done_o    - one-cycle pulse following the last index
//   idx_o     - current index, 0 outside RUN
module rf_dump_ctrl
    import rf_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic          busy_o,
    output logic          valid_o,
    output logic          done_o,
    output logic [AW-1:0] idx_o
);

    localparam logic [AW-1:0] LAST_IDX = '1;

    dump_state_e   state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          busy_q, valid_q, done_q;

    // State, index and status flags; status is decoded from the next state
    // so that every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d != IDLE);
            valid_q <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    // Next state; idx returns to 0 on leaving RUN so it reads 0 when idle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: 2**AW x DW register file with NREAD combinational read ports,
// one write port, hardwired-zero register 0, optional write-to-read bypass,
// link-register write offset, synchronous clear and a streaming dump port.
//   clk, rst - clock, synchronous active-high reset (clears all registers)
//   rf_if    - read/write/dump bus (slave side)
// LINK_REG must be below 2**AW.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 5,
    parameter int unsigned NREAD       = 2,
    parameter int unsigned LINK_REG    = DEF_LINK_REG,
    parameter int unsigned LINK_OFFSET = DEF_LINK_OFFSET,
    parameter bit          BYPASS      = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    rf_multiport_if.slave  rf_if
);

    localparam int unsigned   DEPTH  = 2**AW;
    localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);
    localparam logic [DW-1:0] OFFSET = DW'(LINK_OFFSET);

    logic [DW-1:0]       mem_q [DEPTH];
    logic [DW-1:0]       wv_c;
    logic                wr_en_c;
    logic [NREAD*DW-1:0] rd_c;
    logic [AW-1:0]       dump_idx_c;

    // Value actually stored: link register gets the offset added (mod 2**DW).
    assign wv_c    = (rf_if.wa == LINK_A) ? rf_if.wd + OFFSET : rf_if.wd;
    assign wr_en_c = rf_if.we && (rf_if.wa != ZERO_A);

    // Storage; clear wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            mem_q[rf_if.wa] <= wv_c;
        end
    end

    // Read ports: zero register first, then same-cycle bypass, then storage.
    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [AW-1:0] ra_c;
        logic          hit_c;
        assign ra_c  = rf_if.ra[k*AW +: AW];
        assign hit_c = BYPASS && rf_if.we && (ra_c == rf_if.wa);
        assign rd_c[k*DW +: DW] = (ra_c == ZERO_A) ? '0
                                : hit_c            ? wv_c
                                :                    mem_q[ra_c];
    end

    assign rf_if.rd = rd_c;

    rf_dump_ctrl #(
        .AW (AW)
    ) u_dump_ctrl (
        .clk     (clk),
        .rst     (rst),
        .start_i (rf_if.dump_start),
        .busy_o  (rf_if.dump_busy),
        .valid_o (rf_if.dump_valid),
        .done_o  (rf_if.dump_done),
        .idx_o   (dump_idx_c)
    );

    // Dump shows stored contents only, never the bypassed write value.
    assign rf_if.dump_idx  = dump_idx_c;
    assign rf_if.dump_data = rf_if.dump_valid ? mem_q[dump_idx_c] : '0;

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: scoreboard bench for rf_multiport.
//   dut_a - default build (32x32, 2 read ports, bypass on)
//   dut_b - same as dut_a with bypass off, driven with identical inputs
//   dut_c - 8x16, 4 read ports, link register 7
module tb_rf_multiport;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rf_multiport_if #(.DW(32), .AW(5), .NREAD(2)) ifa ();
    rf_multiport_if #(.DW(32), .AW(5), .NREAD(2)) ifb ();
    rf_multiport_if #(.DW(16), .AW(3), .NREAD(4)) ifc ();

    rf_multiport #(.BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .rf_if(ifa));
    rf_multiport #(.BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .rf_if(ifb));
    rf_multiport #(.DW(16), .AW(3), .NREAD(4), .LINK_REG(7), .LINK_OFFSET(4), .BYPASS(1'b1))
        dut_c (.clk(clk), .rst(rst), .rf_if(ifc));

    // ---------------- reference model ----------------
    logic [31:0] mem_ab [32];
    logic [15:0] mem_c  [8];
    int          pos_ab = -1;   // -1 idle, 0..depth-1 dumping that index, depth = done pulse
    int          pos_c  = -1;

    typedef struct {
        bit          busy;
        bit          valid;
        bit          done;
        logic [31:0] idx;
        logic [31:0] data;
    } dump_exp_t;

    typedef struct {
        string       name;
        int          sel;       // 0,1: A ports; 2,3: B ports; 4..7: C ports
        logic [31:0] exp;
    } rd_exp_t;

    dump_exp_t dq_ab [$];
    dump_exp_t dq_c  [$];
    rd_exp_t   rq    [$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] wv_ab();
        return (ifa.wa == 5'd31) ? ifa.wd + 32'd4 : ifa.wd;
    endfunction

    function automatic logic [15:0] wv_cc();
        return (ifc.wa == 3'd7) ? 16'(ifc.wd + 16'd4) : ifc.wd;
    endfunction

    function automatic int next_pos(int p, logic start, int depth);
        if (p < 0)       return start ? 0 : -1;
        if (p == depth)  return -1;
        return p + 1;
    endfunction

    function automatic dump_exp_t mk_dump(int p, int depth, logic [31:0] d);
        dump_exp_t e;
        e.busy  = (p >= 0);
        e.valid = (p >= 0) && (p < depth);
        e.done  = (p == depth);
        e.idx   = e.valid ? 32'(p) : 32'd0;
        e.data  = e.valid ? d : 32'd0;
        return e;
    endfunction

    // Model advances on each edge; pushes what the dump port must show next cycle.
    always @(posedge clk) begin
        logic [31:0] da;
        logic [31:0] dc;
        if (rst) begin
            for (int i = 0; i < 32; i++) mem_ab[i] = 32'd0;
            for (int i = 0; i < 8; i++)  mem_c[i]  = 16'd0;
            pos_ab = -1;
            pos_c  = -1;
        end else begin
            if (ifa.we && ifa.wa != 5'd0) mem_ab[ifa.wa] = wv_ab();
            if (ifc.we && ifc.wa != 3'd0) mem_c[ifc.wa]  = wv_cc();
            pos_ab = next_pos(pos_ab, ifa.dump_start, 32);
            pos_c  = next_pos(pos_c,  ifc.dump_start, 8);
        end
        da = (pos_ab >= 0 && pos_ab < 32) ? mem_ab[pos_ab] : 32'd0;
        dc = (pos_c >= 0 && pos_c < 8) ? {16'd0, mem_c[pos_c]} : 32'd0;
        dq_ab.push_back(mk_dump(pos_ab, 32, da));
        dq_c.push_back(mk_dump(pos_c, 8, dc));
    end

    function automatic logic [31:0] exp_ab(int ra, bit byp);
        if (ra == 0) return 32'd0;
        if (byp && ifa.we && ra == int'(ifa.wa)) return wv_ab();
        return mem_ab[ra];
    endfunction

    function automatic logic [31:0] exp_c(int ra);
        if (ra == 0) return 32'd0;
        if (ifc.we && ra == int'(ifc.wa)) return {16'd0, wv_cc()};
        return {16'd0, mem_c[ra]};
    endfunction

    task automatic push_rd(string tag, string port, int sel, logic [31:0] exp);
        rd_exp_t r;
        r.name = $sformatf("%s_%s", tag, port);
        r.sel  = sel;
        r.exp  = exp;
        rq.push_back(r);
    endtask

    // Expected read data for the inputs currently applied.
    task automatic expect_reads(string tag);
        logic [4:0] a0, a1;
        logic [2:0] c;
        a0 = ifa.ra[4:0];
        a1 = ifa.ra[9:5];
        push_rd(tag, "A0", 0, exp_ab(int'(a0), 1'b1));
        push_rd(tag, "A1", 1, exp_ab(int'(a1), 1'b1));
        push_rd(tag, "B0", 2, exp_ab(int'(a0), 1'b0));
        push_rd(tag, "B1", 3, exp_ab(int'(a1), 1'b0));
        for (int k = 0; k < 4; k++) begin
            c = ifc.ra[k*3 +: 3];
            push_rd(tag, $sformatf("C%0d", k), 4 + k, exp_c(int'(c)));
        end
    endtask

    // ---------------- monitor ----------------
    function automatic logic [31:0] rd_actual(int sel);
        case (sel)
            0:       return ifa.rd[31:0];
            1:       return ifa.rd[63:32];
            2:       return ifb.rd[31:0];
            3:       return ifb.rd[63:32];
            default: return {16'd0, ifc.rd[(sel-4)*16 +: 16]};
        endcase
    endfunction

    task automatic check(string name, logic [95:0] act, logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] pack_dump(bit busy, bit valid, bit done,
                                              logic [31:0] idx, logic [31:0] data);
        return {29'd0, busy, valid, done, idx, data};
    endfunction

    always @(negedge clk) begin
        dump_exp_t e;
        rd_exp_t   r;
        if (dq_ab.size() > 0) begin
            e = dq_ab.pop_front();
            check("dumpA", pack_dump(ifa.dump_busy, ifa.dump_valid, ifa.dump_done,
                                     32'(ifa.dump_idx), ifa.dump_data),
                  pack_dump(e.busy, e.valid, e.done, e.idx, e.data));
            check("dumpB", pack_dump(ifb.dump_busy, ifb.dump_valid, ifb.dump_done,
                                     32'(ifb.dump_idx), ifb.dump_data),
                  pack_dump(e.busy, e.valid, e.done, e.idx, e.data));
        end
        if (dq_c.size() > 0) begin
            e = dq_c.pop_front();
            check("dumpC", pack_dump(ifc.dump_busy, ifc.dump_valid, ifc.dump_done,
                                     32'(ifc.dump_idx), {16'd0, ifc.dump_data}),
                  pack_dump(e.busy, e.valid, e.done, e.idx, e.data));
        end
        while (rq.size() > 0) begin
            r = rq.pop_front();
            check(r.name, {64'd0, rd_actual(r.sel)}, {64'd0, r.exp});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ab(bit we, int wa, logic [31:0] wd, int ra0, int ra1);
        ifa.we = we;  ifb.we = we;
        ifa.wa = 5'(wa);  ifb.wa = 5'(wa);
        ifa.wd = wd;  ifb.wd = wd;
        ifa.ra = {5'(ra1), 5'(ra0)};
        ifb.ra = {5'(ra1), 5'(ra0)};
    endtask

    task automatic start_ab(bit s);
        ifa.dump_start = s;
        ifb.dump_start = s;
    endtask

    task automatic set_c(bit we, int wa, logic [15:0] wd, int r0, int r1, int r2, int r3);
        ifc.we = we;
        ifc.wa = 3'(wa);
        ifc.wd = wd;
        ifc.ra = {3'(r3), 3'(r2), 3'(r1), 3'(r0)};
    endtask

    task automatic cyc(string tag);
        expect_reads(tag);
        step();
    endtask

    task automatic rand_inputs(bit allow_start);
        int wa, wc;
        wa = $urandom_range(0, 31);
        wc = $urandom_range(0, 7);
        set_ab(1'($urandom_range(0, 1)), wa, $urandom,
               $urandom_range(0, 1) ? wa : $urandom_range(0, 31), $urandom_range(0, 31));
        set_c(1'($urandom_range(0, 1)), wc, 16'($urandom),
              $urandom_range(0, 1) ? wc : $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        start_ab(allow_start && ($urandom_range(0, 19) == 0));
        ifc.dump_start = allow_start && ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        rst = 1'b1;
        set_ab(0, 0, 32'd0, 0, 0);
        start_ab(1'b0);
        set_c(0, 0, 16'd0, 0, 0, 0, 0);
        ifc.dump_start = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Post-reset reads of several registers.
        set_ab(0, 0, 32'd0, 5, 31);
        set_c(0, 0, 16'd0, 1, 2, 3, 7);
        cyc("post_rst");

        // Basic write/read, zero register, link offset, bypass.
        set_ab(1, 5, 32'hDEADBEEF, 0, 5);               cyc("wr_r5");
        set_ab(0, 0, 32'd0, 0, 5);                      cyc("rd_r5");
        set_ab(1, 0, 32'h0000_1234, 0, 0);              cyc("wr_r0");
        set_ab(0, 0, 32'd0, 0, 0);                      cyc("rd_r0");
        set_ab(1, 31, 32'h0040_0000, 31, 0);            cyc("wr_r31a");
        set_ab(0, 0, 32'd0, 0, 31);                     cyc("rd_r31a");
        set_ab(1, 31, 32'hFFFF_FFFE, 0, 31);            cyc("wr_r31b");
        set_ab(0, 0, 32'd0, 31, 0);                     cyc("rd_r31b");
        set_ab(1, 7, 32'h0000_0011, 0, 0);              cyc("pre_r7");
        set_ab(1, 7, 32'hA5A5_A5A5, 7, 7);              cyc("byp_r7");
        set_ab(0, 0, 32'd0, 7, 0);                      cyc("rd_r7");

        // Randomised traffic with occasional dumps, then drain.
        repeat (200) begin
            rand_inputs(1'b1);
            cyc("rand");
        end
        start_ab(1'b0);
        ifc.dump_start = 1'b0;
        repeat (40) begin
            rand_inputs(1'b0);
            cyc("drain");
        end

        // Preload r1..r31 = i (r31 picks up the link offset) and C r1..r7.
        for (int i = 1; i < 32; i++) begin
            set_ab(1, i, 32'(i), $urandom_range(0, 31), i);
            set_c(i < 8, i & 7, 16'(16'h1000 + i * 16'h0111), 1, 2, 3, i & 7);
            cyc("preload");
        end

        // Full dump with start held high; writes to r3 during idx 3 and r10 earlier.
        set_ab(0, 0, 32'd0, 0, 0);
        set_c(0, 0, 16'd0, 0, 0, 0, 0);
        start_ab(1'b1);
        ifc.dump_start = 1'b1;
        cyc("dump_req");
        ifc.dump_start = 1'b0;
        for (int j = 0; j < 34; j++) begin
            if (j == 3)      set_ab(1, 3, 32'h99, 3, 10);
            else if (j == 5) set_ab(1, 10, 32'h99, 10, 3);
            else             set_ab(0, 0, 32'd0, j & 31, 10);
            start_ab(j < 33);
            cyc("dump_run");
        end
        start_ab(1'b0);
        set_ab(0, 0, 32'd0, 3, 10);
        repeat (6) cyc("dump_after");

        // Reset in the middle of a dump, together with a write and dump_start.
        start_ab(1'b1);
        ifc.dump_start = 1'b1;
        cyc("dump2_req");
        start_ab(1'b0);
        ifc.dump_start = 1'b0;
        for (int j = 0; j < 13; j++) begin
            if (j == 12) begin
                rst = 1'b1;
                set_ab(1, 9, 32'h1357_9BDF, 9, 31);
                start_ab(1'b1);
            end else begin
                set_ab(0, 0, 32'd0, 9, 31);
            end
            cyc("dump2_run");
        end
        rst = 1'b0;
        start_ab(1'b0);
        for (int i = 0; i < 32; i += 2) begin
            set_ab(0, 0, 32'd0, i, i + 1);
            set_c(0, 0, 16'd0, i & 7, (i + 1) & 7, (i + 2) & 7, (i + 3) & 7);
            cyc("post_rst2");
        end

        // Narrow build: distinct writes, four simultaneous reads, 8-entry dump.
        for (int i = 1; i < 8; i++) begin
            set_c(1, i, 16'(16'h2000 + i * 16'h0321), 0, 0, 0, 0);
            cyc("c_wr");
        end
        set_c(0, 0, 16'd0, 1, 3, 5, 7);                 cyc("c_rd4a");
        set_c(0, 0, 16'd0, 7, 6, 2, 4);                 cyc("c_rd4b");
        set_c(1, 6, 16'hBEEF, 6, 6, 0, 1);              cyc("c_byp");
        set_c(0, 0, 16'd0, 0, 0, 0, 0);
        ifc.dump_start = 1'b1;
        cyc("c_dump_req");
        ifc.dump_start = 1'b0;
        repeat (12) begin
            set_c(0, 0, 16'd0, $urandom_range(0, 7), 6, 7, 1);
            cyc("c_dump");
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
